// File: rtl/aurora_20g_adc_packer.sv
// aurora_20g_adc_packer
// Packs a header stream (HEAD_WD bits) and a wide ADC word stream (DATA_WD bits)
// into 9-beat frames for an Aurora TX AXI-Stream port.
//   beat0 = {W0 low half, H0}       beat1..3 = {Wk low half, carry}
//   beat4 = {H1, carry}             beat5..8 = W4..W7 unchanged, beat8 carries tlast
// The carry register holds the upper half of the previous ADC word so that the
// header-shifted payload lines up across beats.
// Optional feature: define ADC_PACK_SEQ_STAMP_EN to overwrite the top 16 bits of
// every emitted header with a wrapping 16-bit sequence counter.
// HEAD_WD must equal DATA_WD/2.
module aurora_20g_adc_packer #(
   parameter int DATA_WD = 128,
   parameter int HEAD_WD = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_rst,
   input  logic                 s_head_vld,
   output logic                 s_head_rdy,
   input  logic [HEAD_WD-1:0]   s_head_data,
   input  logic                 s_adc_vld,
   output logic                 s_adc_rdy,
   input  logic [DATA_WD-1:0]   s_adc_data,
   output logic [DATA_WD-1:0]   m_axis_tdata,
   output logic [DATA_WD/8-1:0] m_axis_tkeep,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   input  logic                 m_axis_tready,
   output logic [31:0]          frame_cnt
);

   localparam logic [3:0] S0 = 4'd0;
   localparam logic [3:0] S1 = 4'd1;
   localparam logic [3:0] S2 = 4'd2;
   localparam logic [3:0] S3 = 4'd3;
   localparam logic [3:0] S4 = 4'd4;
   localparam logic [3:0] S5 = 4'd5;
   localparam logic [3:0] S6 = 4'd6;
   localparam logic [3:0] S7 = 4'd7;
   localparam logic [3:0] S8 = 4'd8;

   logic [3:0]         r_state;
   logic [HEAD_WD-1:0] r_carry;
   logic [DATA_WD-1:0] r_tdata;
   logic               r_tvalid;
   logic               r_tlast;
   logic [31:0]        r_frame_cnt;

   logic               w_need_head;
   logic               w_need_adc;
   logic               w_inputs_ok;
   logic               w_out_free;
   logic               w_take;
   logic               w_load_carry;
   logic               w_last_beat;
   logic               w_frame_done;
   logic [3:0]         w_state_nxt;
   logic [HEAD_WD-1:0] w_head;
   logic [DATA_WD-1:0] w_beat;

   // Headers are consumed only in S0 and S4; every other state takes an ADC word.
   assign w_need_head  = (r_state == S0) || (r_state == S4);
   assign w_need_adc   = (r_state != S4);
   assign w_inputs_ok  = (!w_need_head || s_head_vld) && (!w_need_adc || s_adc_vld);
   assign w_out_free   = !r_tvalid || m_axis_tready;

   // A beat is taken only when everything the state needs is present and the
   // output register can accept it; soft and hard reset both suppress it.
   assign w_take       = w_inputs_ok && w_out_free && !cfg_rst && !rst;

   assign s_head_rdy   = w_take && w_need_head;
   assign s_adc_rdy    = w_take && w_need_adc;

   assign w_load_carry = (r_state <= S3);
   assign w_last_beat  = (r_state == S8);
   assign w_state_nxt  = (r_state >= S8) ? S0 : (r_state + 4'd1);
   assign w_frame_done = r_tvalid && r_tlast && m_axis_tready;

`ifdef ADC_PACK_SEQ_STAMP_EN
   logic [15:0] r_seq;

   // Sequence stamp advances once per header actually emitted (S0 and S4 beats).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seq <= '0;
      end else if (cfg_rst) begin
         r_seq <= '0;
      end else if (w_take && w_need_head) begin
         r_seq <= r_seq + 16'd1;
      end
   end

   assign w_head = {r_seq, s_head_data[HEAD_WD-17:0]};
`else
   assign w_head = s_head_data;
`endif

   // Select the outgoing beat layout for the current state.
   always_comb begin
      w_beat = s_adc_data;
      case (r_state)
         S0:         w_beat = {s_adc_data[HEAD_WD-1:0], w_head};
         S1, S2, S3: w_beat = {s_adc_data[HEAD_WD-1:0], r_carry};
         S4:         w_beat = {w_head, r_carry};
         S5, S6, S7, S8: w_beat = s_adc_data;
         default:    w_beat = s_adc_data;
      endcase
   end

   // Framing state and carry: advance one state per taken beat, S8 wraps to S0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S0;
         r_carry <= '0;
      end else if (cfg_rst) begin
         r_state <= S0;
         r_carry <= '0;
      end else if (w_take) begin
         r_state <= w_state_nxt;
         if (w_load_carry) begin
            r_carry <= s_adc_data[DATA_WD-1:HEAD_WD];
         end
      end
   end

   // Registered output stage: load on take, hold while stalled, drop once accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (cfg_rst) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_take) begin
         r_tdata  <= w_beat;
         r_tvalid <= 1'b1;
         r_tlast  <= w_last_beat;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end
   end

   // Count frames as their tlast beat is accepted downstream; a soft reset keeps it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_frame_done) begin
         r_frame_cnt <= r_frame_cnt + 32'd1;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tkeep  = '1;
   assign frame_cnt     = r_frame_cnt;

endmodule
